// File: rtl/rc_operand_stage.sv
// rc_operand_stage
//   R->C and C->M pipeline registers plus C-stage operand resolution.
//   Each source operand is handled by one rc_operand_lane, which owns the
//   operand's data word, source address and "forward consumed" flag, and
//   resolves the operand from the hazard unit's forwarding select.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   rs1Data_R/rs2Data_R/imm_R      R-stage register data and immediate
//   rs1Adr_R/rs2Adr_R/rdAdr_R      R-stage source/destination addresses
//   RegWrite_R/MemEn_R/MemWrite_R/Valid_R  R-stage control
//   AluResult_C                    ALU result for the instruction in C
//   ReadData_W                     load data in writeback
//   Rs1ForwardSrc/Rs2ForwardSrc    00 none, 01 compute(M), 10 memory(W), 11 none
//   StallRC, FlushCM               hazard-unit controls
//   Rs1Operand_C/Rs2Operand_C      resolved operands (combinational)
//   Imm_C, rdAdr_C, RegWrite_C, MemEn_C    C-stage fields
//   AluResult_M, StoreData_M, rdAdr_M, RegWrite_M, MemEn_M, MemWrite_M, Valid_M
//   StallCount                     saturating count of StallRC cycles

module rc_operand_lane #(
  parameter int WORD_SIZE = 32,
  parameter int REG_ADR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 validC,
  input  logic [WORD_SIZE-1:0] dataR,
  input  logic [REG_ADR_W-1:0] adrR,
  input  logic [1:0]           fwdSrc,
  input  logic [WORD_SIZE-1:0] aluResultM,
  input  logic [WORD_SIZE-1:0] readDataW,
  output logic [WORD_SIZE-1:0] operand
);
  localparam logic [1:0] NO_FWD      = 2'b00;
  localparam logic [1:0] FWD_COMPUTE = 2'b01;
  localparam logic [1:0] FWD_MEMORY  = 2'b10;

  logic [WORD_SIZE-1:0] dataC;
  logic [REG_ADR_W-1:0] adrC;
  logic                 fwdUsed;
  logic [1:0]           effSel;

  // Once a compute forward has been captured into dataC the select is stale,
  // so it is ignored; x0 and bubbles are never forwarded.
  always_comb begin
    effSel = fwdSrc;
    if (fwdUsed || (adrC == '0) || !validC || (fwdSrc == 2'b11))
      effSel = NO_FWD;
  end

  always_comb begin
    case (effSel)
      FWD_COMPUTE: operand = aluResultM;
      FWD_MEMORY:  operand = readDataW;
      default:     operand = dataC;
    endcase
  end

  // During a stall the resolved operand is written back into dataC so the
  // value survives its producer retiring. Only COMPUTE marks the forward as
  // consumed: a MEMORY select in a load-use stall sees stale W data and the
  // hazard unit re-presents it on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataC   <= '0;
      adrC    <= '0;
      fwdUsed <= 1'b0;
    end else if (!stall) begin
      dataC   <= dataR;
      adrC    <= adrR;
      fwdUsed <= 1'b0;
    end else begin
      dataC   <= operand;
      fwdUsed <= fwdUsed | (effSel == FWD_COMPUTE);
    end
  end
endmodule

module rc_operand_stage #(
  parameter int WORD_SIZE = 32,
  parameter int REG_ADR_W = $clog2(WORD_SIZE),
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] rs1Data_R,
  input  logic [WORD_SIZE-1:0] rs2Data_R,
  input  logic [WORD_SIZE-1:0] imm_R,
  input  logic [REG_ADR_W-1:0] rs1Adr_R,
  input  logic [REG_ADR_W-1:0] rs2Adr_R,
  input  logic [REG_ADR_W-1:0] rdAdr_R,
  input  logic                 RegWrite_R,
  input  logic                 MemEn_R,
  input  logic                 MemWrite_R,
  input  logic                 Valid_R,
  input  logic [WORD_SIZE-1:0] AluResult_C,
  input  logic [WORD_SIZE-1:0] ReadData_W,
  input  logic [1:0]           Rs1ForwardSrc,
  input  logic [1:0]           Rs2ForwardSrc,
  input  logic                 StallRC,
  input  logic                 FlushCM,
  output logic [WORD_SIZE-1:0] Rs1Operand_C,
  output logic [WORD_SIZE-1:0] Rs2Operand_C,
  output logic [WORD_SIZE-1:0] Imm_C,
  output logic [REG_ADR_W-1:0] rdAdr_C,
  output logic                 RegWrite_C,
  output logic                 MemEn_C,
  output logic [WORD_SIZE-1:0] AluResult_M,
  output logic [WORD_SIZE-1:0] StoreData_M,
  output logic [REG_ADR_W-1:0] rdAdr_M,
  output logic                 RegWrite_M,
  output logic                 MemEn_M,
  output logic                 MemWrite_M,
  output logic                 Valid_M,
  output logic [CNT_W-1:0]     StallCount
);
  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic [WORD_SIZE-1:0] imm;
    logic [REG_ADR_W-1:0] rdAdr;
    logic                 regWrite;
    logic                 memEn;
    logic                 memWrite;
    logic                 valid;
  } rcCtrl_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] aluResult;
    logic [WORD_SIZE-1:0] storeData;
    logic [REG_ADR_W-1:0] rdAdr;
    logic                 regWrite;
    logic                 memEn;
    logic                 memWrite;
    logic                 valid;
  } cmReg_t;

  rcCtrl_t rc;
  cmReg_t  cm;

  logic [NUM_OPS-1:0][WORD_SIZE-1:0] opDataR, opOperand;
  logic [NUM_OPS-1:0][REG_ADR_W-1:0] opAdrR;
  logic [NUM_OPS-1:0][1:0]           opFwdSrc;

  assign opDataR  = {rs2Data_R, rs1Data_R};
  assign opAdrR   = {rs2Adr_R, rs1Adr_R};
  assign opFwdSrc = {Rs2ForwardSrc, Rs1ForwardSrc};

  for (genvar i = 0; i < NUM_OPS; i++) begin : gLane
    rc_operand_lane #(
      .WORD_SIZE(WORD_SIZE),
      .REG_ADR_W(REG_ADR_W)
    ) uLane (
      .clk       (clk),
      .reset     (reset),
      .stall     (StallRC),
      .validC    (rc.valid),
      .dataR     (opDataR[i]),
      .adrR      (opAdrR[i]),
      .fwdSrc    (opFwdSrc[i]),
      .aluResultM(cm.aluResult),
      .readDataW (ReadData_W),
      .operand   (opOperand[i])
    );
  end

  assign Rs1Operand_C = opOperand[0];
  assign Rs2Operand_C = opOperand[1];

  // RC control fields simply hold under stall; data words live in the lanes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rc <= '0;
    end else if (!StallRC) begin
      rc.imm      <= imm_R;
      rc.rdAdr    <= rdAdr_R;
      rc.regWrite <= RegWrite_R;
      rc.memEn    <= MemEn_R;
      rc.memWrite <= MemWrite_R;
      rc.valid    <= Valid_R;
    end
  end

  assign Imm_C      = rc.imm;
  assign rdAdr_C    = rc.rdAdr;
  assign RegWrite_C = rc.regWrite;
  assign MemEn_C    = rc.memEn;

  // CM is independent of StallRC; a stall without a flush duplicates C into M.
  always_ff @(posedge clk) begin
    if (reset || FlushCM) begin
      cm <= '0;
    end else begin
      cm.aluResult <= AluResult_C;
      cm.storeData <= Rs2Operand_C;
      cm.rdAdr     <= rc.rdAdr;
      cm.regWrite  <= rc.regWrite;
      cm.memEn     <= rc.memEn;
      cm.memWrite  <= rc.memWrite;
      cm.valid     <= rc.valid;
    end
  end

  assign AluResult_M = cm.aluResult;
  assign StoreData_M = cm.storeData;
  assign rdAdr_M     = cm.rdAdr;
  assign RegWrite_M  = cm.regWrite;
  assign MemEn_M     = cm.memEn;
  assign MemWrite_M  = cm.memWrite;
  assign Valid_M     = cm.valid;

  always_ff @(posedge clk) begin
    if (reset)
      StallCount <= '0;
    else if (StallRC && (StallCount != {CNT_W{1'b1}}))
      StallCount <= StallCount + 1'b1;
  end
endmodule

// File: tb/tb_rc_operand_stage.sv
// Directed bench for rc_operand_stage: reset, compute/memory forwarding,
// load-use stall, x0 suppression, stall capture, counter saturation and
// reset during a stall.
module tb_rc_operand_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rs1Data_R, rs2Data_R, imm_R;
  logic [4:0]  rs1Adr_R, rs2Adr_R, rdAdr_R;
  logic        RegWrite_R, MemEn_R, MemWrite_R, Valid_R;
  logic [31:0] AluResult_C, ReadData_W;
  logic [1:0]  Rs1ForwardSrc, Rs2ForwardSrc;
  logic        StallRC, FlushCM;
  logic [31:0] Rs1Operand_C, Rs2Operand_C, Imm_C;
  logic [4:0]  rdAdr_C;
  logic        RegWrite_C, MemEn_C;
  logic [31:0] AluResult_M, StoreData_M;
  logic [4:0]  rdAdr_M;
  logic        RegWrite_M, MemEn_M, MemWrite_M, Valid_M;
  logic [15:0] StallCount;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  rc_operand_stage dut (
    .clk(clk), .reset(reset),
    .rs1Data_R(rs1Data_R), .rs2Data_R(rs2Data_R), .imm_R(imm_R),
    .rs1Adr_R(rs1Adr_R), .rs2Adr_R(rs2Adr_R), .rdAdr_R(rdAdr_R),
    .RegWrite_R(RegWrite_R), .MemEn_R(MemEn_R), .MemWrite_R(MemWrite_R), .Valid_R(Valid_R),
    .AluResult_C(AluResult_C), .ReadData_W(ReadData_W),
    .Rs1ForwardSrc(Rs1ForwardSrc), .Rs2ForwardSrc(Rs2ForwardSrc),
    .StallRC(StallRC), .FlushCM(FlushCM),
    .Rs1Operand_C(Rs1Operand_C), .Rs2Operand_C(Rs2Operand_C), .Imm_C(Imm_C),
    .rdAdr_C(rdAdr_C), .RegWrite_C(RegWrite_C), .MemEn_C(MemEn_C),
    .AluResult_M(AluResult_M), .StoreData_M(StoreData_M), .rdAdr_M(rdAdr_M),
    .RegWrite_M(RegWrite_M), .MemEn_M(MemEn_M), .MemWrite_M(MemWrite_M), .Valid_M(Valid_M),
    .StallCount(StallCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleR();
    rs1Data_R = '0; rs2Data_R = '0; imm_R = '0;
    rs1Adr_R = '0; rs2Adr_R = '0; rdAdr_R = '0;
    RegWrite_R = 0; MemEn_R = 0; MemWrite_R = 0; Valid_R = 0;
  endtask

  task automatic quietCtl();
    Rs1ForwardSrc = 2'b00; Rs2ForwardSrc = 2'b00;
    StallRC = 0; FlushCM = 0;
  endtask

  initial begin
    // ---- reset with random inputs ----
    reset = 1;
    for (int c = 0; c < 2; c++) begin
      rs1Data_R = $urandom; rs2Data_R = $urandom; imm_R = $urandom;
      rs1Adr_R = 5'($urandom); rs2Adr_R = 5'($urandom); rdAdr_R = 5'($urandom);
      {RegWrite_R, MemEn_R, MemWrite_R, Valid_R} = 4'($urandom);
      AluResult_C = $urandom; ReadData_W = $urandom;
      Rs1ForwardSrc = 2'($urandom); Rs2ForwardSrc = 2'($urandom);
      StallRC = 1'($urandom); FlushCM = 1'($urandom);
      step();
    end
    chk("rst_AluResult_M", AluResult_M, 0);
    chk("rst_StoreData_M", StoreData_M, 0);
    chk("rst_ctl_M", {rdAdr_M, RegWrite_M, MemEn_M, MemWrite_M, Valid_M}, 0);
    chk("rst_ctl_C", {RegWrite_C, MemEn_C}, 0);
    chk("rst_StallCount", StallCount, 0);
    chk("rst_Rs1Operand", Rs1Operand_C, 0);
    chk("rst_Rs2Operand", Rs2Operand_C, 0);

    reset = 0; idleR(); quietCtl(); AluResult_C = 0; ReadData_W = 0;
    step();
    chk("post_rst_Valid_M", Valid_M, 0);

    // ---- COMPUTE forward ----
    rdAdr_R = 5; RegWrite_R = 1; Valid_R = 1;                // ADD x5
    step();
    AluResult_C = 32'h11;
    idleR(); rs1Adr_R = 5; rs1Data_R = 32'hDEAD_BEEF;       // U reads x5
    rs2Adr_R = 7; rs2Data_R = 32'h77; imm_R = 32'h1234; rdAdr_R = 10;
    RegWrite_R = 1; Valid_R = 1;
    step();
    Rs1ForwardSrc = 2'b01;
    #1;
    chk("fwd_compute_rs1", Rs1Operand_C, 32'h11);
    chk("fwd_none_rs2", Rs2Operand_C, 32'h77);
    chk("add_in_M", {AluResult_M[15:0], 11'(rdAdr_M), RegWrite_M, Valid_M}, {16'h11, 11'd5, 1'b1, 1'b1});
    chk("imm_C", Imm_C, 32'h1234);
    AluResult_C = 32'h99;
    idleR();
    step();
    quietCtl();
    chk("u_store_data", StoreData_M, 32'h77);
    chk("u_alu_M", AluResult_M, 32'h99);
    chk("u_rd_M", rdAdr_M, 10);

    // ---- load-use ----
    rdAdr_R = 6; MemEn_R = 1; RegWrite_R = 1; Valid_R = 1;  // LW x6
    step();
    AluResult_C = 32'h100;
    idleR(); rs1Adr_R = 6; rs1Data_R = 32'hBAD0_0000; rdAdr_R = 8;
    RegWrite_R = 1; Valid_R = 1;
    step();
    chk("lw_in_M", {MemEn_M, Valid_M}, 2'b11);
    StallRC = 1; FlushCM = 1; Rs1ForwardSrc = 2'b10; ReadData_W = 32'hCCCC_CCCC;
    idleR(); rdAdr_R = 31; Valid_R = 1;                     // must be held off
    #1;
    chk("lu_stale_operand", Rs1Operand_C, 32'hCCCC_CCCC);
    chk("lu_count_before", StallCount, 0);
    step();
    StallRC = 0; FlushCM = 0; ReadData_W = 32'h1234_5678;
    idleR();
    #1;
    chk("lu_bubble_Valid_M", Valid_M, 0);
    chk("lu_bubble_MemEn_M", MemEn_M, 0);
    chk("lu_mem_operand", Rs1Operand_C, 32'h1234_5678);
    chk("lu_hold_rdAdr_C", rdAdr_C, 8);
    chk("lu_count", StallCount, 1);
    step();
    quietCtl(); ReadData_W = 0;
    chk("lu_u_in_M", {27'(rdAdr_M), Valid_M}, {27'd8, 1'b1});

    // ---- x0 suppression, 11 select ----
    RegWrite_R = 1; rdAdr_R = 3; Valid_R = 1;
    step();
    AluResult_C = 32'hFFFF_FFFF;
    idleR(); rs1Adr_R = 3; rs1Data_R = 32'h5; rs2Adr_R = 0; rs2Data_R = 0; Valid_R = 1;
    step();
    idleR();
    Rs1ForwardSrc = 2'b01; Rs2ForwardSrc = 2'b01;
    #1;
    chk("x0_suppress", Rs2Operand_C, 0);
    chk("x3_forward", Rs1Operand_C, 32'hFFFF_FFFF);
    Rs1ForwardSrc = 2'b11;
    #1;
    chk("sel11_none", Rs1Operand_C, 32'h5);
    step();
    quietCtl();

    // ---- stall capture, back-to-back stall, fwdUsed release ----
    RegWrite_R = 1; rdAdr_R = 9; Valid_R = 1;
    step();
    AluResult_C = 32'hAA;
    idleR(); rs1Adr_R = 9; rs1Data_R = 32'h55; rdAdr_R = 11; Valid_R = 1;
    step();
    idleR();
    StallRC = 1; FlushCM = 1; Rs1ForwardSrc = 2'b01; AluResult_C = 32'h3C;
    #1;
    chk("cap_forward", Rs1Operand_C, 32'hAA);
    step();
    chk("cap_bubble_alu", AluResult_M, 0);
    chk("cap_hold1", Rs1Operand_C, 32'hAA);
    step();
    chk("cap_hold2", Rs1Operand_C, 32'hAA);
    StallRC = 0; FlushCM = 0;
    rs1Adr_R = 9; rs1Data_R = 32'h1; Valid_R = 1;           // V reads x9 again
    step();
    idleR();
    #1;
    chk("release_fwd", Rs1Operand_C, 32'h3C);
    chk("cap_count", StallCount, 3);
    step();
    quietCtl();

    // ---- saturation ----
    StallRC = 1; FlushCM = 1;
    for (int c = 0; c < 65531; c++) step();
    chk("sat_ffFE", StallCount, 16'hFFFE);
    step();
    chk("sat_ffff", StallCount, 16'hFFFF);
    for (int c = 0; c < 7; c++) step();
    chk("sat_hold", StallCount, 16'hFFFF);

    // ---- reset mid-stall ----
    reset = 1;
    step();
    chk("rst_mid_count", StallCount, 0);
    reset = 0; StallRC = 0; FlushCM = 0;
    rdAdr_R = 12; RegWrite_R = 1; Valid_R = 1; rs1Adr_R = 4; rs1Data_R = 32'h4444;
    step();
    idleR();
    chk("after_rst_load_rd", rdAdr_C, 12);
    chk("after_rst_load_data", Rs1Operand_C, 32'h4444);
    chk("after_rst_regwrite", RegWrite_C, 1);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end
endmodule
